// File: rtl/adder_arbiter_if.sv
// Bundle between adder_arbiter and its environment: two requester handshakes,
// the shared adder operands/result and the response handshake.
interface adder_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_start;
  logic [WIDTH:0]   add_sum;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH:0]   resp_sum;
  logic [7:0]       done_count;

  // Environment side: requesters, adder and response consumer
  modport master (
    output req0_valid, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_a, req1_b, input req1_ready,
    input  add_a, add_b, add_start, output add_sum,
    input  resp_valid, resp_id, resp_sum, done_count, output resp_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_a, req1_b, output req1_ready,
    output add_a, add_b, add_start, input add_sum,
    output resp_valid, resp_id, resp_sum, done_count, input resp_ready
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external adder between two requesters;
// holds operands for ADD_LAT cycles, captures the sum and returns it with the ID.
module adder_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int unsigned CW = 3;
  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_start_q, add_start_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [SW-1:0]    resp_sum_q, resp_sum_d;
  logic [7:0]       done_count_q, done_count_d;
  logic             grant0_c, grant1_c;

  // Grant: on a tie the requester that was not served last wins
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_c = last_q;
        grant1_c = ~last_q;
      end else begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid;
      end
    end
  end

  // Ready is forced low while reset is asserted
  assign bus.req0_ready = grant0_c & rst_n;
  assign bus.req1_ready = grant1_c & rst_n;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_start_d  = 1'b0;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    done_count_d = done_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          add_a_d     = grant1_c ? bus.req1_a : bus.req0_a;
          add_b_d     = grant1_c ? bus.req1_b : bus.req0_b;
          resp_id_d   = grant1_c;
          cnt_d       = CW'(ADD_LAT);
          add_start_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Counter reaching zero marks the cycle add_sum is valid
        if (cnt_q == '0) begin
          resp_sum_d   = bus.add_sum;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          last_d       = resp_id_q;
          done_count_d = done_count_q + 8'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_start_q  <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_start_q  <= add_start_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_start  = add_start_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.done_count = done_count_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model checked every cycle on the
// ADD_LAT=1 instance, plus directed timing checks on ADD_LAT=0 and ADD_LAT=3.
module tb_adder_arbiter;
  localparam int W   = 4;
  localparam int SW  = W + 1;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_arbiter_if #(.WIDTH(W)) b1 ();
  adder_arbiter_if #(.WIDTH(W)) b0 ();
  adder_arbiter_if #(.WIDTH(W)) b3 ();

  adder_arbiter #(.WIDTH(W), .ADD_LAT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
  adder_arbiter #(.WIDTH(W), .ADD_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  adder_arbiter #(.WIDTH(W), .ADD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // Adder models: registered (1 cycle), combinational, 3-stage pipeline
  logic [SW-1:0] s1, p1, p2, p3;
  always @(posedge clk) begin
    s1 <= SW'(b1.add_a) + SW'(b1.add_b);
    p1 <= SW'(b3.add_a) + SW'(b3.add_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign b1.add_sum = s1;
  assign b0.add_sum = SW'(b0.add_a) + SW'(b0.add_b);
  assign b3.add_sum = p3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Transaction-level model: one outstanding transaction, timed from its handshake cycle
  int            mc = 0;
  bit            m_inflight;
  int            m_hs;
  bit            m_last;
  int            m_done;
  logic [W-1:0]  m_a, m_b;
  bit            m_id;
  logic [SW-1:0] m_sum;

  always @(negedge clk) begin : compare
    int age;
    int win;
    bit e_r0, e_r1, e_start, e_rv;
    if (!rst_n) begin
      m_inflight = 1'b0; m_last = 1'b1; m_done = 0;
      m_a = '0; m_b = '0; m_id = 1'b0; m_sum = '0;
      check("rst req0_ready", b1.req0_ready, 0);
      check("rst req1_ready", b1.req1_ready, 0);
      check("rst add_a", b1.add_a, 0);
      check("rst add_start", b1.add_start, 0);
      check("rst resp_valid", b1.resp_valid, 0);
      check("rst resp_sum", b1.resp_sum, 0);
      check("rst done_count", b1.done_count, 0);
    end else begin
      e_r0 = 1'b0; e_r1 = 1'b0; e_start = 1'b0; e_rv = 1'b0; age = 0;
      if (!m_inflight) begin
        if (b1.req0_valid && b1.req1_valid) begin
          win  = m_last ? 0 : 1;
          e_r0 = (win == 0);
          e_r1 = (win == 1);
        end else begin
          e_r0 = b1.req0_valid;
          e_r1 = b1.req1_valid;
        end
      end else begin
        age     = mc - m_hs;
        e_start = (age == 1);
        e_rv    = (age >= LAT + 2);
      end
      check("req0_ready", b1.req0_ready, e_r0);
      check("req1_ready", b1.req1_ready, e_r1);
      check("add_start", b1.add_start, e_start);
      check("add_a", b1.add_a, m_a);
      check("add_b", b1.add_b, m_b);
      check("resp_valid", b1.resp_valid, e_rv);
      check("resp_id", b1.resp_id, m_id);
      check("resp_sum", b1.resp_sum, m_sum);
      check("done_count", b1.done_count, m_done);
      if (!m_inflight) begin
        if (e_r0 || e_r1) begin
          m_inflight = 1'b1;
          m_hs       = mc;
          m_id       = e_r1;
          m_a        = e_r1 ? b1.req1_a : b1.req0_a;
          m_b        = e_r1 ? b1.req1_b : b1.req0_b;
        end
      end else begin
        if (age == LAT + 1) m_sum = SW'(m_a) + SW'(m_b);
        if (e_rv && b1.resp_ready) begin
          m_inflight = 1'b0;
          m_last     = m_id;
          m_done     = (m_done + 1) % 256;
        end
      end
    end
    mc++;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  int nresp;
  int r_id [8];
  int r_sum[8];
  int r_cyc[8];
  int acc;
  int first0, first3;

  initial begin : stim
    rst_n = 1'b0;
    b1.req0_valid = 0; b1.req0_a = '0; b1.req0_b = '0;
    b1.req1_valid = 0; b1.req1_a = '0; b1.req1_b = '0; b1.resp_ready = 0;
    b0.req0_valid = 0; b0.req0_a = '0; b0.req0_b = '0;
    b0.req1_valid = 0; b0.req1_a = '0; b0.req1_b = '0; b0.resp_ready = 0;
    b3.req0_valid = 0; b3.req0_a = '0; b3.req0_b = '0;
    b3.req1_valid = 0; b3.req1_a = '0; b3.req1_b = '0; b3.resp_ready = 0;
    b1.req0_valid = 1;
    repeat (2) tick();
    at_neg();
    check("ready held low in reset", b1.req0_ready, 0);

    // Single request 7+9 right after reset release
    tick();
    b1.req0_a = 4'd7; b1.req0_b = 4'd9; rst_n = 1'b1;
    at_neg();
    check("first ready after reset", b1.req0_ready, 1);
    tick(); b1.req0_valid = 0;
    at_neg(); check("add_start T+1", b1.add_start, 1);
    tick(); at_neg(); check("no resp T+2", b1.resp_valid, 0);
    tick(); at_neg();
    check("resp_valid T+3", b1.resp_valid, 1);
    check("resp_id T+3", b1.resp_id, 0);
    check("resp_sum 7+9", b1.resp_sum, 5'b10000);
    tick(); b1.resp_ready = 1;
    tick(); b1.resp_ready = 0;
    at_neg(); check("done_count 1", b1.done_count, 1);

    // Backpressure: req1 5+6 held in RESP for 5 cycles while req0 waits
    tick(); b1.req1_valid = 1; b1.req1_a = 4'd5; b1.req1_b = 4'd6;
    at_neg();
    check("req1 wins alone", b1.req1_ready, 1);
    check("req0 not ready", b1.req0_ready, 0);
    tick(); b1.req1_valid = 0; b1.req0_valid = 1; b1.req0_a = 4'd1; b1.req0_b = 4'd2;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("bp resp_valid", b1.resp_valid, 1);
      check("bp resp_id", b1.resp_id, 1);
      check("bp resp_sum", b1.resp_sum, 11);
      check("bp req0_ready", b1.req0_ready, 0);
      tick();
    end
    b1.resp_ready = 1;
    tick();
    at_neg();
    check("idle after accept", b1.req0_ready, 1);
    check("done_count 2", b1.done_count, 2);
    tick(); b1.req0_valid = 0; b1.resp_ready = 0;
    tick(); tick(); tick();

    // Asynchronous reset while a response is pending
    #1 rst_n = 1'b0;
    #1;
    check("async rst resp_valid", b1.resp_valid, 0);
    check("async rst done_count", b1.done_count, 0);
    check("async rst add_a", b1.add_a, 0);
    check("async rst resp_sum", b1.resp_sum, 0);

    // Arbitration: both valid continuously from reset
    b1.req0_valid = 1; b1.req0_a = 4'd3;  b1.req0_b = 4'd4;
    b1.req1_valid = 1; b1.req1_a = 4'd15; b1.req1_b = 4'd15;
    b1.resp_ready = 1;
    tick(); tick();
    rst_n = 1'b1;
    nresp = 0;
    for (int i = 0; i < 20; i++) begin
      at_neg();
      if (b1.resp_valid && b1.resp_ready && nresp < 8) begin
        r_id[nresp] = int'(b1.resp_id); r_sum[nresp] = int'(b1.resp_sum); r_cyc[nresp] = i;
        nresp++;
      end
      tick();
    end
    check("arb response count", (nresp >= 4) ? 1 : 0, 1);
    check("arb id0", r_id[0], 0);  check("arb sum0", r_sum[0], 7);
    check("arb id1", r_id[1], 1);  check("arb sum1", r_sum[1], 30);
    check("arb id2", r_id[2], 0);  check("arb sum2", r_sum[2], 7);
    check("arb id3", r_id[3], 1);  check("arb sum3", r_sum[3], 30);
    check("arb first at 3", r_cyc[0], 3);
    for (int k = 0; k < 3; k++) check("arb spacing", r_cyc[k+1] - r_cyc[k], 4);

    // Reset in BUSY (req1 was granted in the last cycle above)
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    at_neg();
    check("tie after reset req0", b1.req0_ready, 1);
    check("tie after reset req1", b1.req1_ready, 0);
    check("flushed resp_valid", b1.resp_valid, 0);
    check("flushed done_count", b1.done_count, 0);
    tick(); b1.req1_valid = 0;

    // Wrap-around: 256 back-to-back transactions from req0
    acc = 0;
    for (int i = 0; i < 2000 && acc < 256; i++) begin
      at_neg();
      if (b1.resp_valid && b1.resp_ready) begin
        acc++;
        if (acc == 256) check("done before wrap", b1.done_count, 255);
      end
      tick();
    end
    check("wrap accept count", acc, 256);
    b1.req0_valid = 0;
    at_neg();
    check("done_count wrapped", b1.done_count, 0);
    tick(); b1.resp_ready = 0;

    // Latency variants ADD_LAT=0 and ADD_LAT=3
    b0.req0_valid = 1; b0.req0_a = 4'd7; b0.req0_b = 4'd9;
    b3.req0_valid = 1; b3.req0_a = 4'd7; b3.req0_b = 4'd9;
    at_neg();
    check("lat0 ready", b0.req0_ready, 1);
    check("lat3 ready", b3.req0_ready, 1);
    tick(); b0.req0_valid = 0; b3.req0_valid = 0;
    first0 = -1; first3 = -1;
    for (int k = 1; k <= 8; k++) begin
      at_neg();
      if (k == 1) begin
        check("lat0 add_start", b0.add_start, 1);
        check("lat3 add_start", b3.add_start, 1);
      end
      if (first0 < 0 && b0.resp_valid) first0 = k;
      if (first3 < 0 && b3.resp_valid) first3 = k;
      tick();
    end
    check("lat0 resp at T+2", first0, 2);
    check("lat3 resp at T+5", first3, 5);
    check("lat0 resp_sum", b0.resp_sum, 16);
    check("lat3 resp_sum", b3.resp_sum, 16);
    check("lat3 resp_id", b3.resp_id, 0);
    b0.resp_ready = 1; b3.resp_ready = 1;
    tick();
    b0.resp_ready = 0; b3.resp_ready = 0;
    at_neg();
    check("lat0 done", b0.done_count, 1);
    check("lat3 done", b3.done_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
